// File: rtl/ps2_send.sv
// ps2_send: host-to-device PS/2 transmitter (inhibit, start, data, parity, stop, ack check).
// Ports: clock/reset, data+send in, busy/done/error out, PS/2 pad values in, active-low pad enables out.
module ps2_send #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bits_q, bits_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    // Pad synchronizers; idle PS/2 lines float high, so reset to 1.
    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic fall;
    logic timed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_i;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_i;
            dat_sync <= dat_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '1;
            cnt_q   <= '0;
            bits_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Time spent with CLK released is bounded by the timeout counter.
    assign timed = (state_q == S_START) || (state_q == S_BITS) ||
                   (state_q == S_ACK)   || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (send) begin
                    state_d = S_INHIBIT;
                    shift_d = {1'b1, ~^data, data};
                    cnt_d   = '0;
                    bits_d  = '0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_START: begin
                // First device edge: bit 0 is already in shift[0].
                if (fall) begin
                    state_d = S_BITS;
                    bits_d  = '0;
                end
            end
            S_BITS: begin
                // Nine more edges: data[7:1], parity, then stop.
                if (fall) begin
                    shift_d = {1'b1, shift_q[9:1]};
                    bits_d  = bits_q + 4'd1;
                    if (bits_q == 4'd8) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!dat_sync) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timeout overrides any event in the same cycle.
        if (timed) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == TO_LAST) begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                error_d = 1'b1;
            end
        end
    end

    // Pad enables decode straight from state so reset releases them at once.
    always_comb begin
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        unique case (state_q)
            S_INHIBIT: ps2_clk_oe = 1'b1;
            S_START:   ps2_dat_oe = 1'b1;
            S_BITS:    ps2_dat_oe = ~shift_q[0];
            default: begin
                ps2_clk_oe = 1'b0;
                ps2_dat_oe = 1'b0;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2_send.sv
// tb_ps2_send: scoreboard bench for ps2_send with a behavioural PS/2 device.
// Ports: none; drives the DUT and a wired-AND model of the two pads.
module tb_ps2_send;

    localparam int INH  = 8;
    localparam int TO   = 400;
    localparam int HALF = 16;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       send  = 1'b0;
    logic       busy, done, error;
    logic       ps2_clk_i, ps2_dat_i;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int nchk  = 0;
    int nfail = 0;

    // 1 = done expected, 0 = error expected.
    logic exp_q[$];
    logic mon_exp;

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    always #5 clock = ~clock;

    ps2_send #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done/error pulse is matched against the scoreboard.
    always @(negedge clock) begin
        if (done || error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, error}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pulse_kind", {30'd0, done, error},
                      mon_exp ? 32'd2 : 32'd1);
            end
            check("end_busy", {31'd0, busy}, 32'd0);
            check("end_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] d);
        @(negedge clock);
        data = d;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
    endtask

    // Device: samples DAT on each CLK rise (release = start bit).
    task automatic device(input int mode, input int nfall,
                          output logic [10:0] frame, output int inh);
        int g;
        frame = '0;
        inh   = 0;
        g     = 0;
        while (!ps2_clk_oe && g < 50) begin
            @(negedge clock);
            g++;
        end
        while (ps2_clk_oe && inh < 50) begin
            inh++;
            @(negedge clock);
        end
        check("start_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        frame[0] = ps2_dat_i;
        if (mode == M_SILENT) return;
        repeat (HALF) @(negedge clock);
        for (int k = 1; k <= nfall; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b1;
            if (k <= 10) frame[k] = ps2_dat_i;
            if (k == 10 && mode == M_ACK) dev_dat = 1'b0;
            if (k == 11) dev_dat = 1'b1;
            repeat (HALF) @(negedge clock);
        end
    endtask

    task automatic wait_resp(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        nchk++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL resp_timeout: %0d responses pending, expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        int          inh;
        int          n;
        int          bad;

        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // 0xED with ack
        exp_q.push_back(1'b1);
        send_byte(8'hED);
        check("ed_busy", {31'd0, busy}, 32'd1);
        check("ed_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        check("ed_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        device(M_ACK, 11, fr, inh);
        check("ed_inhibit", inh, INH);
        check("ed_frame", {21'd0, fr}, {21'd0, 11'b11_1110_1101_0});
        wait_resp(100);
        check("ed_idle_busy", {31'd0, busy}, 32'd0);

        // 0x02: parity 0
        exp_q.push_back(1'b1);
        send_byte(8'h02);
        device(M_ACK, 11, fr, inh);
        check("02_inhibit", inh, INH);
        check("02_frame", {21'd0, fr}, {21'd0, 11'b10_0000_0010_0});
        wait_resp(100);

        // No ack from device
        exp_q.push_back(1'b0);
        send_byte(8'h00);
        device(M_NOACK, 11, fr, inh);
        check("noack_frame", {21'd0, fr}, {21'd0, 11'b11_0000_0000_0});
        wait_resp(100);

        // Device never clocks: timeout
        exp_q.push_back(1'b0);
        send_byte(8'hAA);
        device(M_SILENT, 0, fr, inh);
        n = 0;
        while (!error && n < TO + 50) begin
            @(negedge clock);
            n++;
        end
        check("timeout_cycles", n, TO);
        wait_resp(10);

        // 0xFF with a stray send of 0x55 while busy
        exp_q.push_back(1'b1);
        send_byte(8'hFF);
        fork
            device(M_ACK, 11, fr, inh);
            begin
                repeat (120) @(negedge clock);
                send_byte(8'h55);
                data = 8'h00;
            end
        join
        check("ff_frame", {21'd0, fr}, {21'd0, 11'b11_1111_1111_0});
        wait_resp(100);
        bad = 0;
        repeat (60) begin
            @(negedge clock);
            if (busy || ps2_clk_oe) bad++;
        end
        check("no_resend", bad, 0);

        // Reset in the middle of the data bits
        send_byte(8'h00);
        device(M_ACK, 4, fr, inh);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);

        // 0xF4 after the reset
        exp_q.push_back(1'b1);
        send_byte(8'hF4);
        device(M_ACK, 11, fr, inh);
        check("f4_inhibit", inh, INH);
        check("f4_frame", {21'd0, fr}, {21'd0, 11'b10_1111_0100_0});
        wait_resp(100);
        repeat (10) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
